// File: rtl/psg_pkg.sv
// Shared constants for the PSG voice sequencer: phase width, register map
// offsets, waveform encodings and sequencer state encoding.
package psg_pkg;

   localparam int unsigned PHASE_W = 17;

   localparam logic [1:0] REG_FREQ_LO = 2'd0;
   localparam logic [1:0] REG_FREQ_HI = 2'd1;
   localparam logic [1:0] REG_VOL_PAN = 2'd2;
   localparam logic [1:0] REG_WAVE_PW = 2'd3;

   localparam logic [1:0] WAVE_PULSE = 2'd0;
   localparam logic [1:0] WAVE_SAW   = 2'd1;
   localparam logic [1:0] WAVE_TRI   = 2'd2;
   localparam logic [1:0] WAVE_NOISE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_RD2,
      ST_RD3,
      ST_CAP,
      ST_EMIT
   } seq_state_t;

endpackage

// File: rtl/psg_phase_store.sv
// Per-voice phase accumulator storage: asynchronous read port, synchronous
// write port, cleared on reset.
module psg_phase_store #(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned PHASE_W    = 17
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(NUM_VOICES)-1:0] rd_idx,
   output logic [PHASE_W-1:0]            rd_data,
   input  logic                          we,
   input  logic [$clog2(NUM_VOICES)-1:0] wr_idx,
   input  logic [PHASE_W-1:0]            wr_data
);

   logic [PHASE_W-1:0] mem [NUM_VOICES];

   assign rd_data = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/psg_voice_sequencer.sv
// Frame scheduler: per sample tick, reads each voice's 4 register bytes,
// advances its phase and emits one voice record per 6-cycle slot.
module psg_voice_sequencer #(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned PHASE_W    = psg_pkg::PHASE_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            sample_tick,
   input  logic                            overrun_clr,
   output logic [$clog2(4*NUM_VOICES)-1:0] reg_rdaddr,
   input  logic [7:0]                      reg_rddata,
   output logic                            voice_valid,
   output logic [$clog2(NUM_VOICES)-1:0]   voice_idx,
   output logic [15:0]                     voice_freq,
   output logic [5:0]                      voice_vol,
   output logic [1:0]                      voice_pan,
   output logic [1:0]                      voice_wave,
   output logic [5:0]                      voice_pw,
   output logic [PHASE_W-1:0]              voice_phase,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            overrun
);

   import psg_pkg::*;

   localparam int unsigned IW = $clog2(NUM_VOICES);
   localparam int unsigned AW = $clog2(4*NUM_VOICES);
   localparam logic [IW-1:0] LAST_VOICE = IW'(NUM_VOICES - 1);

   seq_state_t         state;
   logic [IW-1:0]      cur;
   logic [7:0]         freq_lo;
   logic [7:0]         freq_hi;
   logic [7:0]         vol_pan;
   logic [PHASE_W-1:0] phase_rd;
   logic               phase_we;

   // voice_phase already holds phase_new during EMIT, so it is the write data
   assign phase_we = (state == ST_EMIT);

   psg_phase_store #(
      .NUM_VOICES (NUM_VOICES),
      .PHASE_W    (PHASE_W)
   ) u_phase_store (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (cur),
      .rd_data (phase_rd),
      .we      (phase_we),
      .wr_idx  (cur),
      .wr_data (voice_phase)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cur         <= '0;
         freq_lo     <= '0;
         freq_hi     <= '0;
         vol_pan     <= '0;
         reg_rdaddr  <= '0;
         voice_valid <= 1'b0;
         voice_idx   <= '0;
         voice_freq  <= '0;
         voice_vol   <= '0;
         voice_pan   <= '0;
         voice_wave  <= '0;
         voice_pw    <= '0;
         voice_phase <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         voice_valid <= 1'b0;
         frame_done  <= 1'b0;

         if (overrun_clr) begin
            overrun <= 1'b0;
         end
         if (sample_tick && (state != ST_IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (sample_tick) begin
                  state      <= ST_RD0;
                  cur        <= '0;
                  busy       <= 1'b1;
                  reg_rdaddr <= AW'({IW'(0), REG_FREQ_LO});
               end
            end
            ST_RD0: begin
               state      <= ST_RD1;
               reg_rdaddr <= AW'({cur, REG_FREQ_HI});
            end
            ST_RD1: begin
               state      <= ST_RD2;
               freq_lo    <= reg_rddata;
               reg_rdaddr <= AW'({cur, REG_VOL_PAN});
            end
            ST_RD2: begin
               state      <= ST_RD3;
               freq_hi    <= reg_rddata;
               reg_rdaddr <= AW'({cur, REG_WAVE_PW});
            end
            ST_RD3: begin
               state   <= ST_CAP;
               vol_pan <= reg_rddata;
            end
            ST_CAP: begin
               // last byte is consumed straight off the bus into the record
               state       <= ST_EMIT;
               voice_valid <= 1'b1;
               voice_idx   <= cur;
               voice_freq  <= {freq_hi, freq_lo};
               voice_pan   <= vol_pan[7:6];
               voice_vol   <= vol_pan[5:0];
               voice_wave  <= reg_rddata[7:6];
               voice_pw    <= reg_rddata[5:0];
               voice_phase <= phase_rd + PHASE_W'({freq_hi, freq_lo});
               frame_done  <= (cur == LAST_VOICE);
            end
            ST_EMIT: begin
               if (cur == LAST_VOICE) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state      <= ST_RD0;
                  cur        <= cur + IW'(1);
                  reg_rdaddr <= AW'({cur + IW'(1), REG_FREQ_LO});
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psg_voice_sequencer.sv
// Scoreboard bench for psg_voice_sequencer: directed frames push expected voice
// records; a negedge monitor pops and compares on every voice_valid.
module tb_psg_voice_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_tick;
   logic        overrun_clr;
   logic [4:0]  reg_rdaddr;
   logic [7:0]  reg_rddata = 8'h00;
   logic        voice_valid;
   logic [2:0]  voice_idx;
   logic [15:0] voice_freq;
   logic [5:0]  voice_vol;
   logic [1:0]  voice_pan;
   logic [1:0]  voice_wave;
   logic [5:0]  voice_pw;
   logic [16:0] voice_phase;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   typedef struct {
      int          cyc;
      logic [2:0]  idx;
      logic [15:0] freq;
      logic [5:0]  vol;
      logic [1:0]  pan;
      logic [1:0]  wave;
      logic [5:0]  pw;
      logic [16:0] phase;
      logic        fd;
   } rec_t;

   rec_t       exp_q[$];
   logic [7:0] ram [0:31];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   psg_voice_sequencer #(
      .NUM_VOICES (8),
      .PHASE_W    (17)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .overrun_clr (overrun_clr),
      .reg_rdaddr  (reg_rdaddr),
      .reg_rddata  (reg_rddata),
      .voice_valid (voice_valid),
      .voice_idx   (voice_idx),
      .voice_freq  (voice_freq),
      .voice_vol   (voice_vol),
      .voice_pan   (voice_pan),
      .voice_wave  (voice_wave),
      .voice_pw    (voice_pw),
      .voice_phase (voice_phase),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      reg_rddata <= ram[reg_rdaddr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
      end
   endtask

   // monitor: every presented record must match the head of the scoreboard
   always @(negedge clk) begin
      if (voice_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_emit_idx", {29'd0, voice_idx}, 32'hFFFF_FFFF);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            check("emit_cycle", cyc, e.cyc);
            check("voice_idx", {29'd0, voice_idx}, {29'd0, e.idx});
            check("voice_freq", {16'd0, voice_freq}, {16'd0, e.freq});
            check("voice_vol", {26'd0, voice_vol}, {26'd0, e.vol});
            check("voice_pan", {30'd0, voice_pan}, {30'd0, e.pan});
            check("voice_wave", {30'd0, voice_wave}, {30'd0, e.wave});
            check("voice_pw", {26'd0, voice_pw}, {26'd0, e.pw});
            check("voice_phase", {15'd0, voice_phase}, {15'd0, e.phase});
            check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
         end
      end else if (frame_done) begin
         check("frame_done_without_valid", {31'd0, frame_done}, 32'd0);
      end
   end

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic start_frame(output int t0);
      t0 = cyc;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   // voice 0 and voice 3 carry the hand-set registers; all other voices are zero
   task automatic push_frame(input int t0, input int nv, input logic [16:0] p0, input logic [16:0] p3);
      for (int v = 0; v < nv; v++) begin
         rec_t r;
         r.cyc = t0 + 6 + 6*v;
         r.idx = 3'(v);
         r.freq = 16'h0000; r.vol = 6'h00; r.pan = 2'd0; r.wave = 2'd0; r.pw = 6'h00; r.phase = 17'h0;
         if (v == 0) begin
            r.freq = 16'h0F00; r.pan = 2'd3; r.vol = 6'h3F; r.wave = 2'd1; r.pw = 6'h00; r.phase = p0;
         end else if (v == 3) begin
            r.freq = 16'hFFFF; r.pan = 2'd2; r.vol = 6'h05; r.wave = 2'd3; r.pw = 6'h07; r.phase = p3;
         end
         r.fd = (v == 7);
         exp_q.push_back(r);
      end
   endtask

   function automatic logic [7:0] sweep_byte(input int a);
      return 8'(a*7 + 3);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, voice_valid}, 32'd0);
      check({tag, "_idx"}, {29'd0, voice_idx}, 32'd0);
      check({tag, "_freq"}, {16'd0, voice_freq}, 32'd0);
      check({tag, "_volpanwavepw"}, {16'd0, voice_vol, voice_pan, voice_wave, voice_pw}, 32'd0);
      check({tag, "_phase"}, {15'd0, voice_phase}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
      check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
      check({tag, "_rdaddr"}, {27'd0, reg_rdaddr}, 32'd0);
   endtask

   initial begin
      int t0;
      int t1;
      rst = 1'b1;
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      for (int a = 0; a < 32; a++) ram[a] = 8'h00;
      ram[0] = 8'h00; ram[1] = 8'h0F; ram[2] = 8'hFF; ram[3] = 8'h40;
      ram[12] = 8'hFF; ram[13] = 8'hFF; ram[14] = 8'h85; ram[15] = 8'hC7;

      wait_to(10);
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_to(12);

      // frame 1: busy window and first phases
      start_frame(t0);
      push_frame(t0, 8, 17'h00F00, 17'h0FFFF);
      wait_to(t0 + 1);  check("busy_start", {31'd0, busy}, 32'd1);
      wait_to(t0 + 48); check("busy_last", {31'd0, busy}, 32'd1);
      wait_to(t0 + 49); check("busy_end", {31'd0, busy}, 32'd0);
      check("overrun_clean", {31'd0, overrun}, 32'd0);
      wait_to(t0 + 52);

      // frame 2: accumulation and voice-3 wrap
      start_frame(t0);
      push_frame(t0, 8, 17'h01E00, 17'h1FFFE);
      wait_to(t0 + 52);

      // frame 3: mid-frame tick is dropped and sets sticky overrun
      start_frame(t0);
      push_frame(t0, 8, 17'h02D00, 17'h0FFFD);
      wait_to(t0 + 10);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      wait_to(t0 + 12); check("overrun_set", {31'd0, overrun}, 32'd1);
      wait_to(t0 + 45); check("overrun_sticky", {31'd0, overrun}, 32'd1);
      wait_to(t0 + 52); check("overrun_held", {31'd0, overrun}, 32'd1);
      check("frame3_drained", exp_q.size(), 32'd0);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("overrun_cleared", {31'd0, overrun}, 32'd0);

      // frame 4: tick in final EMIT (with clr, set wins), tick one cycle later starts frame 5
      start_frame(t0);
      push_frame(t0, 8, 17'h03C00, 17'h1FFFC);
      wait_to(t0 + 48);
      sample_tick = 1'b1;
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("overrun_set_wins", {31'd0, overrun}, 32'd1);
      check("busy_idle_gap", {31'd0, busy}, 32'd0);
      start_frame(t1);
      push_frame(t1, 8, 17'h04B00, 17'h0FFFB);
      wait_to(t1 + 1); check("busy_back_to_back", {31'd0, busy}, 32'd1);
      wait_to(t1 + 52);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("overrun_cleared2", {31'd0, overrun}, 32'd0);

      // frame 6: reset at T+20 aborts after voice 2
      start_frame(t0);
      push_frame(t0, 3, 17'h05A00, 17'h0);
      wait_to(t0 + 20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("midreset");
      wait_to(t0 + 60);
      check("abort_drained", exp_q.size(), 32'd0);

      // frame 7: phases were cleared, so phase equals freq again
      start_frame(t0);
      push_frame(t0, 8, 17'h00F00, 17'h0FFFF);
      wait_to(t0 + 52);
      check("frame7_drained", exp_q.size(), 32'd0);

      // sweep: distinct bytes in every register of every voice, fresh phases
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 32; a++) ram[a] = sweep_byte(a);
      @(negedge clk);
      start_frame(t0);
      for (int v = 0; v < 8; v++) begin
         rec_t r;
         logic [7:0] b2;
         logic [7:0] b3;
         b2 = sweep_byte(4*v + 2);
         b3 = sweep_byte(4*v + 3);
         r.cyc = t0 + 6 + 6*v;
         r.idx = 3'(v);
         r.freq = {sweep_byte(4*v + 1), sweep_byte(4*v)};
         r.pan = b2[7:6];
         r.vol = b2[5:0];
         r.wave = b3[7:6];
         r.pw = b3[5:0];
         r.phase = {1'b0, r.freq};
         r.fd = (v == 7);
         exp_q.push_back(r);
      end
      wait_to(t0 + 1); check("rdaddr_rd0", {27'd0, reg_rdaddr}, 32'd0);
      wait_to(t0 + 2); check("rdaddr_rd1", {27'd0, reg_rdaddr}, 32'd1);
      wait_to(t0 + 3); check("rdaddr_rd2", {27'd0, reg_rdaddr}, 32'd2);
      wait_to(t0 + 4); check("rdaddr_rd3", {27'd0, reg_rdaddr}, 32'd3);
      wait_to(t0 + 7); check("rdaddr_v1_rd0", {27'd0, reg_rdaddr}, 32'd4);
      wait_to(t0 + 52);
      check("rdaddr_idle_hold", {27'd0, reg_rdaddr}, 32'd31);
      check("sweep_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
